mem_arbiter: RTL and testbench

- Shares one single-port simram (1-cycle registered read) between the cpu16 instruction-read port and the data read/write port.
- The instruction and data programs then live in one unified memory.
- Sits between cpu16 and the RAM. It preserves the cpu16 req/rdy handshake on both sides, so cpu16 is unchanged.
- Issues at most one RAM access per cycle. Arbitration is round-robin or fixed-priority.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port RAM (registered read, 1-cycle latency)
//               between the cpu16 instruction-read port and the data
//               read/write port, keeping the req/rdy handshake of both sides.
//               At most one RAM access is issued per cycle. Contention is
//               resolved round-robin (FIXED_PRIO=0) or data-first
//               (FIXED_PRIO=1).
// Ports       :
//   clk, reset              clock, synchronous active-high reset
//   i_ins_rd_addr/_req      instruction read request
//   o_ins_rd_data/_rdy      instruction read data and completion pulse
//   i_dat_rw_addr           data address (read or write)
//   i_dat_wr_data           write data
//   i_dat_rd_req/_wr_req    data read / write requests
//   o_dat_rd_data/_rdy      data read data and completion pulse
//   o_dat_wr_rdy            data write completion pulse
//   o_mem_addr/_wdata       RAM address / write data (combinational)
//   o_mem_we/_re            RAM write / read enables (combinational)
//   i_mem_rdata             RAM read data, valid one cycle after o_mem_re
//   o_ins_stall_count       saturating count of unserved instruction cycles
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AWIDTH     = 16,
  parameter int DWIDTH     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] i_ins_rd_addr,
  input  logic              i_ins_rd_req,
  output logic [DWIDTH-1:0] o_ins_rd_data,
  output logic              o_ins_rd_rdy,
  input  logic [AWIDTH-1:0] i_dat_rw_addr,
  input  logic [DWIDTH-1:0] i_dat_wr_data,
  input  logic              i_dat_rd_req,
  input  logic              i_dat_wr_req,
  output logic [DWIDTH-1:0] o_dat_rd_data,
  output logic              o_dat_rd_rdy,
  output logic              o_dat_wr_rdy,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic [15:0]       o_ins_stall_count
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INS  = 2'd1,
    GNT_DRD  = 2'd2,
    GNT_DWR  = 2'd3
  } grant_t;

  grant_t      w_grant;
  grant_t      w_dat_kind;
  logic        w_contended;
  grant_t      r_inflight;
  // 1 when the instruction port won the most recent contended cycle.
  logic        r_last_ins;
  logic [15:0] r_stall_count;

  // A simultaneous read+write from the data port is served write-first;
  // the read stays asserted by the requester and is taken later.
  assign w_dat_kind  = i_dat_wr_req ? GNT_DWR : GNT_DRD;
  assign w_contended = i_ins_rd_req && (i_dat_rd_req || i_dat_wr_req);

  always_comb begin
    w_grant = GNT_NONE;
    if (!reset) begin
      if (w_contended) begin
        if ((FIXED_PRIO != 0) || r_last_ins) begin
          w_grant = w_dat_kind;
        end else begin
          w_grant = GNT_INS;
        end
      end else if (i_ins_rd_req) begin
        w_grant = GNT_INS;
      end else if (i_dat_rd_req || i_dat_wr_req) begin
        w_grant = w_dat_kind;
      end
    end
  end

  // RAM command decode; idle cycles still present the instruction address.
  always_comb begin
    o_mem_addr = i_ins_rd_addr;
    o_mem_re   = 1'b0;
    o_mem_we   = 1'b0;
    case (w_grant)
      GNT_INS: begin
        o_mem_re = 1'b1;
      end
      GNT_DRD: begin
        o_mem_addr = i_dat_rw_addr;
        o_mem_re   = 1'b1;
      end
      GNT_DWR: begin
        o_mem_addr = i_dat_rw_addr;
        o_mem_we   = 1'b1;
      end
      default: begin
        o_mem_addr = i_ins_rd_addr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight    <= GNT_NONE;
      r_last_ins    <= 1'b1;
      r_stall_count <= 16'd0;
    end else begin
      r_inflight <= w_grant;
      if (w_contended) begin
        r_last_ins <= (w_grant == GNT_INS);
      end
      if (i_ins_rd_req && (w_grant != GNT_INS) && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  // Gating with reset kills a completion that falls due in a reset cycle,
  // so a grant issued just before reset never reports back.
  assign o_ins_rd_rdy = (r_inflight == GNT_INS) && !reset;
  assign o_dat_rd_rdy = (r_inflight == GNT_DRD) && !reset;
  assign o_dat_wr_rdy = (r_inflight == GNT_DWR) && !reset;

  assign o_ins_rd_data     = i_mem_rdata;
  assign o_dat_rd_data     = i_mem_rdata;
  assign o_mem_wdata       = i_dat_wr_data;
  assign o_ins_stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: reference model of the
//               arbitration rules plus a RAM image, a vector table, directed
//               corner sequences and a randomized requester phase. A second
//               instance exercises the fixed-priority configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int G_NONE = 0;
  localparam int G_INS  = 1;
  localparam int G_DRD  = 2;
  localparam int G_DWR  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- round-robin instance ----------------
  logic        reset;
  logic [15:0] ins_addr, dat_addr, wdata;
  logic        ins_req, drd, dwr;
  logic [15:0] ins_rd_data, dat_rd_data, mem_addr, mem_wdata, stall;
  logic        ins_rdy, drd_rdy, dwr_rdy, mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic [15:0] ram [0:65535];

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .reset(reset),
    .i_ins_rd_addr(ins_addr), .i_ins_rd_req(ins_req),
    .o_ins_rd_data(ins_rd_data), .o_ins_rd_rdy(ins_rdy),
    .i_dat_rw_addr(dat_addr), .i_dat_wr_data(wdata),
    .i_dat_rd_req(drd), .i_dat_wr_req(dwr),
    .o_dat_rd_data(dat_rd_data), .o_dat_rd_rdy(drd_rdy), .o_dat_wr_rdy(dwr_rdy),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_re(mem_re),
    .i_mem_rdata(mem_rdata), .o_ins_stall_count(stall)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // ---------------- fixed-priority instance ----------------
  logic        f_reset;
  logic [15:0] f_iaddr, f_daddr, f_wdata;
  logic        f_ins, f_drd, f_dwr;
  logic [15:0] f_ins_data, f_dat_data, f_mem_addr, f_mem_wdata, f_stall;
  logic        f_ins_rdy, f_drd_rdy, f_dwr_rdy, f_mem_we, f_mem_re;
  logic [15:0] f_rdata;

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .reset(f_reset),
    .i_ins_rd_addr(f_iaddr), .i_ins_rd_req(f_ins),
    .o_ins_rd_data(f_ins_data), .o_ins_rd_rdy(f_ins_rdy),
    .i_dat_rw_addr(f_daddr), .i_dat_wr_data(f_wdata),
    .i_dat_rd_req(f_drd), .i_dat_wr_req(f_dwr),
    .o_dat_rd_data(f_dat_data), .o_dat_rd_rdy(f_drd_rdy), .o_dat_wr_rdy(f_dwr_rdy),
    .o_mem_addr(f_mem_addr), .o_mem_wdata(f_mem_wdata),
    .o_mem_we(f_mem_we), .o_mem_re(f_mem_re),
    .i_mem_rdata(f_rdata), .o_ins_stall_count(f_stall)
  );

  // Trivial RAM for the fixed-priority instance: content is ~address.
  always @(posedge clk) begin
    if (f_mem_re) f_rdata <= ~f_mem_addr;
  end

  // ---------------- scoring ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] refmem [0:65535];
  int          m_inflight = G_NONE;   // access whose completion is due next cycle
  bit          m_ins_won  = 1'b1;     // winner of last contention was instruction
  int          m_stall    = 0;
  logic [15:0] m_exp_data = 16'h0;
  int          last_g;
  int          obs_grant;
  logic [2:0]  obs_rdy;               // {ins, dat_rd, dat_wr}
  logic [15:0] obs_ins_data, obs_dat_data, obs_stall;

  function automatic logic [2:0] rdy_mask(input int g);
    case (g)
      G_INS:   return 3'b100;
      G_DRD:   return 3'b010;
      G_DWR:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // One clock of the round-robin instance: checks at negedge, model advances
  // at posedge, inputs may be changed by the caller on return.
  task automatic cycle();
    int          g;
    int          dk;
    logic [2:0]  exp_rdy;
    @(negedge clk);
    dk = dwr ? G_DWR : G_DRD;
    g  = G_NONE;
    if (!reset) begin
      if (ins_req && (drd || dwr))
        g = m_ins_won ? dk : G_INS;   // the side that lost last time goes now
      else if (ins_req)
        g = G_INS;
      else if (drd || dwr)
        g = dk;
    end
    exp_rdy = reset ? 3'b000 : rdy_mask(m_inflight);
    check("mem_re", mem_re, (g == G_INS) || (g == G_DRD));
    check("mem_we", mem_we, g == G_DWR);
    check("mem_addr", mem_addr, (g == G_DRD || g == G_DWR) ? dat_addr : ins_addr);
    check("mem_wdata", mem_wdata, wdata);
    obs_rdy = {ins_rdy, drd_rdy, dwr_rdy};
    check("rdy", obs_rdy, exp_rdy);
    if (exp_rdy[2]) check("ins_rd_data", ins_rd_data, m_exp_data);
    if (exp_rdy[1]) check("dat_rd_data", dat_rd_data, m_exp_data);
    check("stall_count", stall, m_stall);
    obs_grant    = mem_we ? G_DWR : (mem_re ? ((mem_addr == dat_addr && ins_addr != dat_addr) ? G_DRD : G_INS) : G_NONE);
    obs_ins_data = ins_rd_data;
    obs_dat_data = dat_rd_data;
    obs_stall    = stall;
    @(posedge clk);
    if (reset) begin
      m_inflight = G_NONE;
      m_ins_won  = 1'b1;
      m_stall    = 0;
    end else begin
      m_inflight = g;
      if (ins_req && (drd || dwr)) m_ins_won = (g == G_INS);
      if (ins_req && g != G_INS && m_stall < 65535) m_stall++;
      if (g == G_INS) m_exp_data = refmem[ins_addr];
      if (g == G_DRD) m_exp_data = refmem[dat_addr];
      if (g == G_DWR) refmem[dat_addr] = wdata;
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ins_req = 1'b0; drd = 1'b0; dwr = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic       ins;
    logic       rd;
    logic       wr;
    logic [1:0] g;
    logic [2:0] rdy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, expected to have finished");
    $fatal(1);
  end

  initial begin
    int n_ins, n_dat;
    bit ip, rp, wp;

    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 16'h1000 + 16'(i);
      refmem[i] = 16'h1000 + 16'(i);
    end
    reset = 1'b1; ins_req = 1'b0; drd = 1'b0; dwr = 1'b0;
    ins_addr = 16'h0; dat_addr = 16'h0; wdata = 16'h0;
    f_reset = 1'b1; f_ins = 1'b0; f_drd = 1'b0; f_dwr = 1'b0;
    f_iaddr = 16'h0; f_daddr = 16'h0; f_wdata = 16'h0;
    @(posedge clk); #1;

    // --- reset in the cycle after an instruction grant ---
    do_reset();
    repeat (8) cycle();
    ins_req = 1'b1; ins_addr = 16'h0005;
    cycle();
    check("rst_mid_grant", obs_grant, G_INS);
    reset = 1'b1;
    cycle();
    check("rst_mid_rdy_suppressed", obs_rdy, 3'b000);
    cycle();
    reset = 1'b0; ins_req = 1'b0;
    cycle();
    check("rst_mid_no_late_rdy", obs_rdy, 3'b000);
    check("rst_mid_stall_zero", obs_stall, 0);

    // --- back-to-back instruction stream ---
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ins_req = 1'b1; ins_addr = 16'(k);
      cycle();
      check("istream_grant", obs_grant, G_INS);
      if (k > 0) begin
        check("istream_rdy", obs_rdy, 3'b100);
        check("istream_data", obs_ins_data, 16'h1000 + 16'(k - 1));
      end
    end
    ins_req = 1'b0;
    cycle();
    check("istream_last_data", obs_ins_data, 16'h1003);
    check("istream_stall", obs_stall, 0);

    // --- vector table: consecutive cycles from reset ---
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'(G_NONE), 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'(G_INS),  3'b000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'(G_DRD),  3'b100};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'(G_DWR),  3'b010};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'(G_DRD),  3'b001};  // first contention: data wins
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'(G_INS),  3'b010};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'(G_DWR),  3'b100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'(G_INS),  3'b001};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'(G_DWR),  3'b100};  // illegal dual: write first
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'(G_DRD),  3'b001};  // pending read follows
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'(G_NONE), 3'b010};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'(G_INS),  3'b000};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2'(G_DRD),  3'b100};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'(G_NONE), 3'b010};
    do_reset();
    ins_addr = 16'h0011; dat_addr = 16'h0022; wdata = 16'h5A5A;
    for (int v = 0; v < 14; v++) begin
      ins_req = tbl[v].ins; drd = tbl[v].rd; dwr = tbl[v].wr;
      cycle();
      check($sformatf("tbl%0d_grant", v), obs_grant, 32'(tbl[v].g));
      check($sformatf("tbl%0d_rdy", v), obs_rdy, tbl[v].rdy);
    end

    // --- round-robin contention for 8 cycles ---
    do_reset();
    ins_addr = 16'h0031; dat_addr = 16'h0030;
    ins_req = 1'b1; drd = 1'b1; dwr = 1'b0;
    n_ins = 0; n_dat = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_grant", obs_grant, (i % 2 == 0) ? G_DRD : G_INS);
      n_ins += int'(obs_rdy[2]);
      n_dat += int'(obs_rdy[1]);
    end
    ins_req = 1'b0; drd = 1'b0;
    cycle();
    n_ins += int'(obs_rdy[2]);
    n_dat += int'(obs_rdy[1]);
    check("rr_ins_pulses", n_ins, 4);
    check("rr_dat_pulses", n_dat, 4);
    check("rr_stall", obs_stall, 4);

    // --- write then read back ---
    do_reset();
    dwr = 1'b1; dat_addr = 16'h0040; wdata = 16'hBEEF;
    cycle();
    check("wrb_write_grant", obs_grant, G_DWR);
    dwr = 1'b0; drd = 1'b1; wdata = 16'h0000;
    cycle();
    check("wrb_wr_rdy", obs_rdy, 3'b001);
    drd = 1'b0;
    cycle();
    check("wrb_rd_rdy", obs_rdy, 3'b010);
    check("wrb_rd_data", obs_dat_data, 16'hBEEF);

    // --- randomized requesters holding req/addr until granted ---
    do_reset();
    ip = 1'b0; rp = 1'b0; wp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom_range(0, 99) == 0);
      if (!ip) begin
        ins_addr = 16'($urandom_range(0, 63));
        ip = $urandom_range(0, 1) == 1;
      end
      if (!rp && !wp) begin
        dat_addr = 16'($urandom_range(0, 63));
        wdata    = 16'($urandom);
        r = $urandom_range(0, 15);
        rp = (r >= 4 && r <= 9) || r == 15;
        wp = (r <= 3) || r == 15;
      end
      ins_req = ip; drd = rp; dwr = wp;
      cycle();
      if (last_g == G_INS) ip = 1'b0;
      if (last_g == G_DRD) rp = 1'b0;
      if (last_g == G_DWR) wp = 1'b0;
    end
    reset = 1'b0; ins_req = 1'b0; drd = 1'b0; dwr = 1'b0;
    cycle();
    cycle();

    // --- fixed priority: data starves instruction for 20 cycles ---
    f_reset = 1'b0; f_ins = 1'b1; f_drd = 1'b1;
    f_iaddr = 16'h0007; f_daddr = 16'h0008;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("fp_addr", f_mem_addr, 16'h0008);
      check("fp_ins_rdy", f_ins_rdy, 1'b0);
      check("fp_dat_rdy", f_drd_rdy, k > 0);
      @(posedge clk); #1;
    end
    f_drd = 1'b0;
    @(negedge clk);
    check("fp_stall", f_stall, 20);
    check("fp_ins_grant_addr", f_mem_addr, 16'h0007);
    check("fp_ins_grant_re", f_mem_re, 1'b1);
    @(posedge clk); #1;
    f_ins = 1'b0;
    @(negedge clk);
    check("fp_ins_rdy_after", f_ins_rdy, 1'b1);
    check("fp_ins_data", f_ins_data, 16'hFFF8);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
